// File: rtl/memory_bram_arbiter_pkg.sv
// Shared definitions for the internal-memory BRAM wrappers: FSM encodings and byte-lane constants.
package memory_defines;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int BYTE_W = 8;

  // All-lanes-enabled mask for the default 32-bit word.
  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/memory_byte_merge.sv
// Per-byte-lane select between a new word and an old word; building block for byte-enable RAM wrappers.
module memory_byte_merge
  import memory_defines::*;
#(
  parameter int data_size = 32
) (
  input  logic [data_size/BYTE_W-1:0] i_be,
  input  logic [data_size-1:0]        i_new,
  input  logic [data_size-1:0]        i_old,
  output logic [data_size-1:0]        o_merged
);

  for (genvar k = 0; k < data_size/BYTE_W; k++) begin : g_lane
    assign o_merged[k*BYTE_W +: BYTE_W] = i_be[k] ? i_new[k*BYTE_W +: BYTE_W]
                                                  : i_old[k*BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/memory_bram_arbiter.sv
// Two-requester round-robin arbiter for one BRAM port; adds byte enables through read-modify-write.
module memory_bram_arbiter
  import memory_defines::*;
#(
  parameter int data_size = 32,
  parameter int addr_size = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        m0_req,
  input  logic                        m0_wr,
  input  logic [addr_size-1:0]        m0_addr,
  input  logic [data_size/BYTE_W-1:0] m0_be,
  input  logic [data_size-1:0]        m0_din,
  output logic [data_size-1:0]        m0_dout,
  output logic                        m0_ack,
  input  logic                        m1_req,
  input  logic                        m1_wr,
  input  logic [addr_size-1:0]        m1_addr,
  input  logic [data_size/BYTE_W-1:0] m1_be,
  input  logic [data_size-1:0]        m1_din,
  output logic [data_size-1:0]        m1_dout,
  output logic                        m1_ack,
  output logic                        mem_wr,
  output logic [addr_size-1:0]        mem_addr,
  output logic [data_size-1:0]        mem_din,
  input  logic [data_size-1:0]        mem_dout
);

  localparam int NB = data_size / BYTE_W;

  state_t               r_state, w_next;
  logic                 r_req0, r_req1, r_last, r_gnt, r_wr;
  logic [NB-1:0]        r_be;
  logic [addr_size-1:0] r_mem_addr;
  logic [data_size-1:0] r_din, r_mem_din, r_dout0, r_dout1, w_merged;
  logic                 w_any, w_pick, w_full, w_zero;

  assign w_any  = r_req0 | r_req1;
  assign w_pick = (r_req0 & r_req1) ? ~r_last : r_req1;
  assign w_full = r_wr & (&r_be);
  assign w_zero = ~|r_be;

  memory_byte_merge #(.data_size(data_size)) u_merge (
    .i_be     (r_be),
    .i_new    (r_din),
    .i_old    (mem_dout),
    .o_merged (w_merged)
  );

  // Every access enters through READ so reads, full writes and zero-mask writes share one latency;
  // only a partial write pays the extra cycle for its merge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = READ;
      READ:    w_next = w_full ? WRITE : DATA;
      DATA:    w_next = (r_wr && !w_zero) ? WRITE : DONE;
      WRITE:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_req0     <= 1'b0;
      r_req1     <= 1'b0;
      r_last     <= 1'b1;
      r_gnt      <= 1'b0;
      r_wr       <= 1'b0;
      r_be       <= '0;
      r_din      <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_dout0    <= '0;
      r_dout1    <= '0;
    end else begin
      r_state <= w_next;
      r_req0  <= m0_req;
      r_req1  <= m1_req;
      case (r_state)
        IDLE: if (w_any) begin
          r_gnt      <= w_pick;
          r_last     <= w_pick;
          r_wr       <= w_pick ? m1_wr   : m0_wr;
          r_be       <= w_pick ? m1_be   : m0_be;
          r_din      <= w_pick ? m1_din  : m0_din;
          r_mem_addr <= w_pick ? m1_addr : m0_addr;
        end
        READ: if (w_full) r_mem_din <= r_din;
        DATA: begin
          if (!r_wr) begin
            if (r_gnt) r_dout1 <= mem_dout;
            else       r_dout0 <= mem_dout;
          end else if (!w_zero) begin
            r_mem_din <= w_merged;
          end
        end
        default: ;
      endcase
    end
  end

  assign m0_ack   = (r_state == DONE) && !r_gnt;
  assign m1_ack   = (r_state == DONE) &&  r_gnt;
  assign m0_dout  = r_dout0;
  assign m1_dout  = r_dout1;
  assign mem_wr   = (r_state == WRITE);
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;

endmodule

// File: tb/tb_memory_bram_arbiter.sv
// Directed bench for memory_bram_arbiter with a behavioural 1-cycle-latency BRAM.
module tb_memory_bram_arbiter;
  import memory_defines::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [9:0]  m0_addr = '0, m1_addr = '0;
  logic [3:0]  m0_be = '0, m1_be = '0;
  logic [31:0] m0_din = '0, m1_din = '0, m0_dout, m1_dout;
  logic        m0_ack, m1_ack, mem_wr;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;

  logic [31:0] ram [0:1023];
  logic [31:0] last_wdata;
  int          wr_cnt = 0, ack_cnt = 0;
  int          n_chk = 0, n_fail = 0;

  memory_bram_arbiter #(.data_size(32), .addr_size(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_be(m0_be), .m0_din(m0_din),
    .m0_dout(m0_dout), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_be(m1_be), .m1_din(m1_din),
    .m1_dout(m1_dout), .m1_ack(m1_ack),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_addr] <= mem_din;
      wr_cnt        <= wr_cnt + 1;
      last_wdata    <= mem_din;
    end
    mem_dout <= ram[mem_addr];
  end

  always @(negedge clk) ack_cnt <= ack_cnt + int'(m0_ack) + int'(m1_ack);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request and returns the ack cycle index (0 = first cycle the request is visible).
  task automatic xfer(input bit align, input bit id, input bit wr, input logic [9:0] addr,
                      input logic [3:0] be, input logic [31:0] din,
                      output int lat, output logic [31:0] dout);
    if (align) begin @(posedge clk); #1; end
    if (id) begin m1_wr = wr; m1_addr = addr; m1_be = be; m1_din = din; m1_req = 1'b1; end
    else    begin m0_wr = wr; m0_addr = addr; m0_be = be; m0_din = din; m0_req = 1'b1; end
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? m1_ack : m0_ack) begin lat = i; break; end
    end
    dout = id ? m1_dout : m0_dout;
    if (id) m1_req = 1'b0; else m0_req = 1'b0;
    if (lat < 0) chk("xfer_ack_seen", {31'b0, (id ? m1_ack : m0_ack)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, w0, a0, n;
    logic [31:0] d, prev0, prev1;
    logic [31:0] exp0 [2];
    logic [31:0] exp1 [2];

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_acks", {30'b0, m1_ack, m0_ack}, 32'd0);
    chk("rst_mem", {21'b0, mem_wr, mem_addr}, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_douts", m0_dout | m1_dout, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // full write then read back
    w0 = wr_cnt;
    xfer(1, 0, 1, 10'h005, BE_ALL, 32'hDEADBEEF, lat, d);
    chk("fw_lat", lat, 32'd4);
    @(negedge clk);
    chk("fw_ack_one_cycle", {31'b0, m0_ack}, 32'd0);
    chk("fw_wr_count", wr_cnt - w0, 32'd1);
    chk("fw_wdata", last_wdata, 32'hDEADBEEF);
    xfer(1, 0, 0, 10'h005, 4'h0, 32'h0, lat, d);
    chk("rd_lat", lat, 32'd4);
    chk("rd_data", d, 32'hDEADBEEF);

    // partial write via read-modify-write
    w0 = wr_cnt;
    xfer(1, 1, 1, 10'h005, 4'b0101, 32'h11223344, lat, d);
    chk("pw_lat", lat, 32'd5);
    @(negedge clk);
    chk("pw_wr_count", wr_cnt - w0, 32'd1);
    chk("pw_wdata", last_wdata, 32'hDE22BE44);
    xfer(1, 1, 0, 10'h005, 4'h0, 32'h0, lat, d);
    chk("pw_readback", d, 32'hDE22BE44);

    // setup contents, then zero-mask write is a no-op
    xfer(1, 1, 1, 10'h010, BE_ALL, 32'h12345678, lat, d);
    xfer(1, 0, 1, 10'h020, BE_ALL, 32'hA5A50F0F, lat, d);
    xfer(1, 1, 1, 10'h3FF, BE_ALL, 32'hCAFEF00D, lat, d);
    w0 = wr_cnt;
    xfer(1, 0, 1, 10'h010, 4'h0, 32'hFFFFFFFF, lat, d);
    chk("zb_lat", lat, 32'd4);
    @(negedge clk);
    chk("zb_no_write", wr_cnt - w0, 32'd0);
    xfer(1, 0, 0, 10'h010, 4'h0, 32'h0, lat, d);
    chk("zb_readback", d, 32'h12345678);

    // reset during DATA of a partial write aborts it
    @(posedge clk); #1;
    w0 = wr_cnt;
    m1_wr = 1'b1; m1_addr = 10'h005; m1_be = 4'b0011; m1_din = 32'hFFFFFFFF; m1_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("mid_rst_acks", {30'b0, m1_ack, m0_ack}, 32'd0);
    chk("mid_rst_m0_dout", m0_dout, 32'd0);
    chk("mid_rst_m1_dout", m1_dout, 32'd0);
    chk("mid_rst_mem", {21'b0, mem_wr, mem_addr}, 32'd0);
    chk("mid_rst_mem_din", mem_din, 32'd0);
    m1_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_write", wr_cnt - w0, 32'd0);
    xfer(1, 0, 0, 10'h005, 4'h0, 32'h0, lat, d);
    chk("mid_rst_readback", d, 32'hDE22BE44);

    // fairness: both request continuously from a fresh reset
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    exp0[0] = 32'hDE22BE44; exp0[1] = 32'hCAFEF00D;
    exp1[0] = 32'h12345678; exp1[1] = 32'hA5A50F0F;
    prev0 = 32'd0; prev1 = 32'd0; n = 0;
    @(posedge clk); #1;
    m0_wr = 1'b0; m0_addr = 10'h005; m0_req = 1'b1;
    m1_wr = 1'b0; m1_addr = 10'h010; m1_req = 1'b1;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        chk("alt_order", {31'b0, m1_ack}, n % 2);
        chk("alt_single_ack", {31'b0, m0_ack & m1_ack}, 32'd0);
        if (m0_ack) begin
          chk("alt_m0_dout", m0_dout, exp0[n/2]);
          chk("alt_m1_hold", m1_dout, prev1);
          prev0 = exp0[n/2];
          if (n == 0) m0_addr = 10'h3FF; else m0_req = 1'b0;
        end else begin
          chk("alt_m1_dout", m1_dout, exp1[n/2]);
          chk("alt_m0_hold", m0_dout, prev0);
          prev1 = exp1[n/2];
          if (n == 1) m1_addr = 10'h020; else m1_req = 1'b0;
        end
        n++;
      end
    end
    chk("alt_ack_count", n, 32'd4);
    m0_req = 1'b0; m1_req = 1'b0;

    // back-to-back: new request issued in the ack cycle
    @(posedge clk);
    a0 = ack_cnt;
    xfer(1, 0, 0, 10'h020, 4'h0, 32'h0, lat, d);
    chk("b2b_lat1", lat, 32'd4);
    chk("b2b_data1", d, 32'hA5A50F0F);
    xfer(0, 0, 0, 10'h3FF, 4'h0, 32'h0, lat, d);
    chk("b2b_gap", lat + 1, 32'd4);
    chk("b2b_data2", d, 32'hCAFEF00D);
    repeat (4) @(negedge clk);
    chk("b2b_ack_total", ack_cnt - a0, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
